// File: rtl/udp_echo_responder_if.sv
// UDP header + payload stream bundle shared by the RX (slave) and TX (master)
// sides of udp_echo_responder.
interface udp_echo_responder_if;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] ip_source_ip;
  logic [31:0] ip_dest_ip;
  logic [7:0]  ip_ttl;
  logic [15:0] source_port;
  logic [15:0] dest_port;
  logic [15:0] length;
  logic [7:0]  payload_axis_tdata;
  logic        payload_axis_tvalid;
  logic        payload_axis_tready;
  logic        payload_axis_tlast;
  logic        payload_axis_tuser;

  modport master (
    output hdr_valid, ip_source_ip, ip_dest_ip, ip_ttl, source_port, dest_port, length,
    output payload_axis_tdata, payload_axis_tvalid, payload_axis_tlast, payload_axis_tuser,
    input  hdr_ready, payload_axis_tready
  );

  modport slave (
    input  hdr_valid, ip_source_ip, ip_dest_ip, ip_ttl, source_port, dest_port, length,
    input  payload_axis_tdata, payload_axis_tvalid, payload_axis_tlast, payload_axis_tuser,
    output hdr_ready, payload_axis_tready
  );
endinterface

// File: rtl/udp_echo_responder.sv
// UDP echo responder: buffers one packet addressed to an enabled listen port and
// replies to its sender. Define UDP_ECHO_STATS_EN to add the statistics counters.
module udp_echo_responder #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned TTL       = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  udp_echo_responder_if.slave      s_udp,
  udp_echo_responder_if.master     m_udp,
  input  logic [31:0]              local_ip,
  input  logic [16*NUM_PORTS-1:0]  listen_ports,
  input  logic [NUM_PORTS-1:0]     port_enable
`ifdef UDP_ECHO_STATS_EN
  ,
  output logic [31:0]              stat_echoed,
  output logic [31:0]              stat_drop_port,
  output logic [31:0]              stat_drop_error
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, STORE, DROP, TX_HDR, TX_PAYLOAD} state_t;

  state_t        r_state;
  logic          r_s_hdr_ready;
  logic          r_s_tready;
  logic [31:0]   r_src_ip;
  logic [15:0]   r_src_port;
  logic [15:0]   r_dst_port;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_rd_ptr;
  logic [7:0]    r_mem [DEPTH];

  logic          r_m_hdr_valid;
  logic [31:0]   r_m_source_ip;
  logic [31:0]   r_m_dest_ip;
  logic [7:0]    r_m_ttl;
  logic [15:0]   r_m_source_port;
  logic [15:0]   r_m_dest_port;
  logic [15:0]   r_m_length;
  logic          r_m_tvalid;
  logic [7:0]    r_m_tdata;
  logic          r_m_tlast;

  logic w_port_hit;
  logic w_hdr_fire;
  logic w_rx_fire;
  logic w_full;
  logic w_m_hdr_fire;
  logic w_tx_fire;
  logic w_wr_en;
  logic w_unused;

  // Listen-port lookup against the header currently offered.
  always_comb begin
    w_port_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (port_enable[i] && (listen_ports[16*i +: 16] == s_udp.dest_port)) begin
        w_port_hit = 1'b1;
      end
    end
  end

  assign w_hdr_fire   = s_udp.hdr_valid & r_s_hdr_ready;
  assign w_rx_fire    = s_udp.payload_axis_tvalid & r_s_tready;
  assign w_full       = (r_count == FULL_COUNT);
  assign w_m_hdr_fire = r_m_hdr_valid & m_udp.hdr_ready;
  assign w_tx_fire    = r_m_tvalid & m_udp.payload_axis_tready;
  assign w_wr_en      = (r_state == STORE) & w_rx_fire & ~w_full;

  // Request TTL, destination IP and length are not needed to build the reply.
  assign w_unused = ^{s_udp.ip_dest_ip, s_udp.ip_ttl, s_udp.length};

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_count[AW-1:0]] <= s_udp.payload_axis_tdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_s_hdr_ready   <= 1'b1;
      r_s_tready      <= 1'b0;
      r_src_ip        <= '0;
      r_src_port      <= '0;
      r_dst_port      <= '0;
      r_count         <= '0;
      r_rd_ptr        <= '0;
      r_m_hdr_valid   <= 1'b0;
      r_m_source_ip   <= '0;
      r_m_dest_ip     <= '0;
      r_m_ttl         <= '0;
      r_m_source_port <= '0;
      r_m_dest_port   <= '0;
      r_m_length      <= '0;
      r_m_tvalid      <= 1'b0;
      r_m_tdata       <= '0;
      r_m_tlast       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hdr_fire) begin
            r_src_ip      <= s_udp.ip_source_ip;
            r_src_port    <= s_udp.source_port;
            r_dst_port    <= s_udp.dest_port;
            r_count       <= '0;
            r_s_hdr_ready <= 1'b0;
            r_s_tready    <= 1'b1;
            r_state       <= w_port_hit ? STORE : DROP;
          end
        end

        STORE: begin
          if (w_rx_fire) begin
            if (w_full) begin
              // Oversize: stop storing, flush the rest of the packet.
              if (s_udp.payload_axis_tlast) begin
                r_state       <= IDLE;
                r_s_hdr_ready <= 1'b1;
                r_s_tready    <= 1'b0;
              end else begin
                r_state <= DROP;
              end
            end else begin
              r_count <= r_count + CW'(1);
              if (s_udp.payload_axis_tlast) begin
                r_s_tready <= 1'b0;
                if (s_udp.payload_axis_tuser) begin
                  r_state       <= IDLE;
                  r_s_hdr_ready <= 1'b1;
                end else begin
                  r_state         <= TX_HDR;
                  r_m_hdr_valid   <= 1'b1;
                  r_m_source_ip   <= local_ip;
                  r_m_dest_ip     <= r_src_ip;
                  r_m_ttl         <= 8'(TTL);
                  r_m_source_port <= r_dst_port;
                  r_m_dest_port   <= r_src_port;
                  r_m_length      <= 16'(r_count) + 16'd9;
                end
              end
            end
          end
        end

        DROP: begin
          if (w_rx_fire && s_udp.payload_axis_tlast) begin
            r_state       <= IDLE;
            r_s_hdr_ready <= 1'b1;
            r_s_tready    <= 1'b0;
          end
        end

        TX_HDR: begin
          // Prefetch byte 0 with the header handshake so payload starts at full rate.
          if (w_m_hdr_fire) begin
            r_m_hdr_valid <= 1'b0;
            r_m_tvalid    <= 1'b1;
            r_m_tdata     <= r_mem[0];
            r_m_tlast     <= (r_count == CW'(1));
            r_rd_ptr      <= CW'(1);
            r_state       <= TX_PAYLOAD;
          end
        end

        TX_PAYLOAD: begin
          if (w_tx_fire) begin
            if (r_m_tlast) begin
              r_m_tvalid    <= 1'b0;
              r_m_tlast     <= 1'b0;
              r_state       <= IDLE;
              r_s_hdr_ready <= 1'b1;
            end else begin
              r_m_tdata <= r_mem[r_rd_ptr[AW-1:0]];
              r_m_tlast <= (r_rd_ptr == (r_count - CW'(1)));
              r_rd_ptr  <= r_rd_ptr + CW'(1);
            end
          end
        end

        default: begin
          r_state       <= IDLE;
          r_s_hdr_ready <= 1'b1;
          r_s_tready    <= 1'b0;
          r_m_hdr_valid <= 1'b0;
          r_m_tvalid    <= 1'b0;
        end
      endcase
    end
  end

  assign s_udp.hdr_ready           = r_s_hdr_ready;
  assign s_udp.payload_axis_tready = r_s_tready;

  assign m_udp.hdr_valid           = r_m_hdr_valid;
  assign m_udp.ip_source_ip        = r_m_source_ip;
  assign m_udp.ip_dest_ip          = r_m_dest_ip;
  assign m_udp.ip_ttl              = r_m_ttl;
  assign m_udp.source_port         = r_m_source_port;
  assign m_udp.dest_port           = r_m_dest_port;
  assign m_udp.length              = r_m_length;
  assign m_udp.payload_axis_tdata  = r_m_tdata;
  assign m_udp.payload_axis_tvalid = r_m_tvalid;
  assign m_udp.payload_axis_tlast  = r_m_tlast;
  assign m_udp.payload_axis_tuser  = 1'b0;

`ifdef UDP_ECHO_STATS_EN
  logic        w_evt_echo;
  logic        w_evt_port;
  logic        w_evt_err;
  logic [31:0] r_stat_echoed;
  logic [31:0] r_stat_drop_port;
  logic [31:0] r_stat_drop_error;

  // Error drops: tuser-flagged tail or first byte past a full buffer.
  assign w_evt_echo = (r_state == TX_PAYLOAD) & w_tx_fire & r_m_tlast;
  assign w_evt_port = (r_state == IDLE) & w_hdr_fire & ~w_port_hit;
  assign w_evt_err  = (r_state == STORE) & w_rx_fire &
                      (w_full | (s_udp.payload_axis_tlast & s_udp.payload_axis_tuser));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_echoed     <= '0;
      r_stat_drop_port  <= '0;
      r_stat_drop_error <= '0;
    end else begin
      if (w_evt_echo) r_stat_echoed     <= r_stat_echoed + 32'd1;
      if (w_evt_port) r_stat_drop_port  <= r_stat_drop_port + 32'd1;
      if (w_evt_err)  r_stat_drop_error <= r_stat_drop_error + 32'd1;
    end
  end

  assign stat_echoed     = r_stat_echoed;
  assign stat_drop_port  = r_stat_drop_port;
  assign stat_drop_error = r_stat_drop_error;
`endif

endmodule

// File: tb/tb_udp_echo_responder.sv
// Scoreboard bench for udp_echo_responder: directed packets push expected replies,
// a negedge monitor pops and compares every TX header and payload beat.
module tb_udp_echo_responder;
  localparam int unsigned NP       = 4;
  localparam int unsigned DEPTH    = 64;
  localparam int unsigned TTL      = 64;
  localparam int          WAIT_MAX = 2000;
  localparam logic [31:0] LOCAL_IP = 32'hC0A8_0001;

  typedef struct packed {
    logic [31:0] dip;
    logic [31:0] sip;
    logic [7:0]  ttl;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
  } hdr_t;

  logic clk = 1'b0;
  logic reset;
  logic [31:0]      local_ip;
  logic [16*NP-1:0] listen_ports;
  logic [NP-1:0]    port_enable;
`ifdef UDP_ECHO_STATS_EN
  logic [31:0] stat_echoed, stat_drop_port, stat_drop_error;
`endif

  udp_echo_responder_if rx();
  udp_echo_responder_if tx();

  udp_echo_responder #(.NUM_PORTS(NP), .DEPTH(DEPTH), .TTL(TTL)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_udp        (rx),
    .m_udp        (tx),
    .local_ip     (local_ip),
    .listen_ports (listen_ports),
    .port_enable  (port_enable)
`ifdef UDP_ECHO_STATS_EN
    ,
    .stat_echoed     (stat_echoed),
    .stat_drop_port  (stat_drop_port),
    .stat_drop_error (stat_drop_error)
`endif
  );

  always #5 clk = ~clk;

  hdr_t       exp_hdr[$];
  logic [8:0] exp_byte[$];
  int n_checks = 0;
  int n_errors = 0;
  bit bp = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no handshake within %0d cycles, required one", name, WAIT_MAX);
  endtask

  // TX ready generator, optionally random backpressure.
  initial begin
    tx.hdr_ready = 1'b0;
    tx.payload_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx.hdr_ready           = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      tx.payload_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares every TX transfer against the scoreboard queues.
  initial begin
    hdr_t cur, held, e;
    logic [8:0] eb;
    bit hold_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_pending = 1'b0;
      end else begin
        cur = '{dip: tx.ip_dest_ip, sip: tx.ip_source_ip, ttl: tx.ip_ttl,
                sp: tx.source_port, dp: tx.dest_port, len: tx.length};
        if (hold_pending && tx.hdr_valid) check("hdr_stable", 128'(cur), 128'(held));
        hold_pending = tx.hdr_valid && !tx.hdr_ready;
        held = cur;
        if (tx.hdr_valid && tx.hdr_ready) begin
          check("hdr_expected", 128'(exp_hdr.size() != 0), 128'(1));
          if (exp_hdr.size() != 0) begin
            e = exp_hdr.pop_front();
            check("hdr_fields", 128'(cur), 128'(e));
          end
        end
        if (tx.payload_axis_tvalid && tx.payload_axis_tready) begin
          check("byte_expected", 128'(exp_byte.size() != 0), 128'(1));
          if (exp_byte.size() != 0) begin
            eb = exp_byte.pop_front();
            check("byte_last_data", 128'({tx.payload_axis_tlast, tx.payload_axis_tdata}), 128'(eb));
            check("byte_tuser", 128'(tx.payload_axis_tuser), 128'(0));
          end
        end
      end
    end
  end

  task automatic wait_hs(input bit is_hdr, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < WAIT_MAX; t++) begin
      @(negedge clk);
      if (is_hdr ? rx.hdr_ready : rx.payload_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [31:0] sip, input logic [15:0] sp, input logic [15:0] dp,
                          input int n, input logic [7:0] base, input bit err, input bit echo);
    bit ok;
    if (echo) begin
      exp_hdr.push_back('{dip: sip, sip: LOCAL_IP, ttl: 8'(TTL), sp: dp, dp: sp, len: 16'(n + 8)});
      for (int k = 0; k < n; k++) exp_byte.push_back({(k == n - 1), 8'(base + 8'(k))});
    end
    rx.hdr_valid    = 1'b1;
    rx.ip_source_ip = sip;
    rx.ip_dest_ip   = LOCAL_IP;
    rx.ip_ttl       = 8'd32;
    rx.source_port  = sp;
    rx.dest_port    = dp;
    rx.length       = 16'(n + 8);
    wait_hs(1'b1, ok);
    rx.hdr_valid = 1'b0;
    if (!ok) begin
      timeout_fail("hdr_accept");
      return;
    end
    for (int k = 0; k < n; k++) begin
      rx.payload_axis_tvalid = 1'b1;
      rx.payload_axis_tdata  = 8'(base + 8'(k));
      rx.payload_axis_tlast  = (k == n - 1);
      rx.payload_axis_tuser  = err && (k == n - 1);
      wait_hs(1'b0, ok);
      if (!ok) begin
        timeout_fail("payload_accept");
        break;
      end
    end
    rx.payload_axis_tvalid = 1'b0;
    rx.payload_axis_tlast  = 1'b0;
    rx.payload_axis_tuser  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 4 * WAIT_MAX; t++) begin
      if (exp_hdr.size() == 0 && exp_byte.size() == 0) break;
      @(posedge clk);
    end
    check({name, "_hdr_left"}, 128'(exp_hdr.size()), 128'(0));
    check({name, "_bytes_left"}, 128'(exp_byte.size()), 128'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_hdr_ready"}, 128'(rx.hdr_ready), 128'(1));
    check({name, "_tready"}, 128'(rx.payload_axis_tready), 128'(0));
  endtask

  initial begin
    logic [15:0] ports [3];
    bit ok;
    ports[0] = 16'd7;
    ports[1] = 16'd1234;
    ports[2] = 16'd80;

    reset = 1'b1;
    local_ip = LOCAL_IP;
    listen_ports = {16'd80, 16'd1234, 16'd9, 16'd7};
    port_enable  = 4'b1101;
    rx.hdr_valid = 1'b0;
    rx.ip_source_ip = '0;
    rx.ip_dest_ip = '0;
    rx.ip_ttl = '0;
    rx.source_port = '0;
    rx.dest_port = '0;
    rx.length = '0;
    rx.payload_axis_tdata = '0;
    rx.payload_axis_tvalid = 1'b0;
    rx.payload_axis_tlast = 1'b0;
    rx.payload_axis_tuser = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_s_hdr_ready", 128'(rx.hdr_ready), 128'(1));
    check("rst_s_tready", 128'(rx.payload_axis_tready), 128'(0));
    check("rst_m_hdr_valid", 128'(tx.hdr_valid), 128'(0));
    check("rst_m_tvalid", 128'(tx.payload_axis_tvalid), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_hdr_ready", 128'(rx.hdr_ready), 128'(1));
`ifdef UDP_ECHO_STATS_EN
    check("rst_stat_echoed", 128'(stat_echoed), 128'(0));
`endif
    @(posedge clk);
    #1;

    // Basic echo on entry 0.
    send_pkt(32'h0A00_0005, 16'd5000, 16'd7, 4, 8'h01, 1'b0, 1'b1);
    drain("echo4");

    // Port 9 configured but disabled.
    send_pkt(32'h0A00_0006, 16'd6000, 16'd9, 20, 8'h40, 1'b0, 1'b0);
    check_idle("drop_port");
`ifdef UDP_ECHO_STATS_EN
    check("stat_drop_port", 128'(stat_drop_port), 128'(1));
`endif

    // tuser-flagged tail discards, next packet echoes.
    send_pkt(32'h0A00_0007, 16'd7000, 16'd1234, 10, 8'h80, 1'b1, 1'b0);
    check_idle("drop_tuser");
    send_pkt(32'h0A00_0008, 16'd7001, 16'd1234, 5, 8'hA0, 1'b0, 1'b1);
    drain("after_tuser");

    // Oversize is dropped, exactly-full packet echoes with length 72.
    send_pkt(32'h0A00_0009, 16'd8000, 16'd80, 100, 8'h10, 1'b0, 1'b0);
    check_idle("drop_oversize");
    send_pkt(32'h0A00_000A, 16'd8001, 16'd80, 64, 8'hC0, 1'b0, 1'b1);
    drain("full64");
`ifdef UDP_ECHO_STATS_EN
    check("stat_drop_error", 128'(stat_drop_error), 128'(2));
`endif

    // Back-to-back packets under random TX backpressure.
    bp = 1'b1;
    for (int p = 0; p < 50; p++) begin
      send_pkt(32'h0A01_0000 + 32'(p), 16'(20000 + p), ports[$urandom_range(0, 2)],
               int'($urandom_range(1, 64)), 8'($urandom_range(0, 255)), 1'b0, 1'b1);
    end
    drain("random_bp");
    bp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef UDP_ECHO_STATS_EN
    check("stat_echoed_53", 128'(stat_echoed), 128'(53));
`endif

    // Reset while the third payload byte of an 8-byte reply is on the bus.
    send_pkt(32'h0A00_000B, 16'd9000, 16'd7, 8, 8'h21, 1'b0, 1'b1);
    ok = 1'b0;
    for (int t = 0; t < WAIT_MAX; t++) begin
      @(negedge clk);
      #2;
      if (exp_byte.size() <= 5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("reach_byte3");
    reset = 1'b1;
    #1;
    check("midrst_m_tvalid", 128'(tx.payload_axis_tvalid), 128'(0));
    check("midrst_m_hdr_valid", 128'(tx.hdr_valid), 128'(0));
    check("midrst_s_hdr_ready", 128'(rx.hdr_ready), 128'(1));
    exp_hdr.delete();
    exp_byte.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("after_rst_no_tvalid", 128'(tx.payload_axis_tvalid), 128'(0));
    send_pkt(32'h0A00_000C, 16'd9001, 16'd7, 8, 8'h31, 1'b0, 1'b1);
    drain("after_rst");
`ifdef UDP_ECHO_STATS_EN
    check("stat_echoed_after_rst", 128'(stat_echoed), 128'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
